enemy_bullet_controller: RTL and testbench

//   Downward (enemy->player) counterpart of the player bullet path. Spawns bullets from the

---
 rtl/enemy_bullet_controller.sv | 144 ++++++++++++++
 tb/tb_enemy_bullet_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_bullet_controller.sv
// Enemy bullet slots: timed spawning from the enemy sprite, per-frame
// downward motion, retirement at the screen bottom and player hit detection.
module enemy_bullet_controller #(
  parameter int BULLET_COUNT = 4,
  parameter int BULLET_SPEED = 3,
  parameter int FIRE_PERIOD  = 45,
  parameter int SCREEN_H     = 480
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      enemy_alive,
  input  logic [9:0]                enemy_x,
  input  logic [9:0]                enemy_y,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  output logic [10*BULLET_COUNT-1:0] ebullet_x,
  output logic [10*BULLET_COUNT-1:0] ebullet_y,
  output logic [BULLET_COUNT-1:0]   ebullet_active,
  output logic [BULLET_COUNT-1:0]   hit_mask,
  output logic                      player_hit,
  output logic [7:0]                hit_count
);

  localparam int CW = $clog2(FIRE_PERIOD + 1);

  typedef enum logic {
    S_WAIT,
    S_ARMED
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    fire;
  logic                    free_any;
  logic [BULLET_COUNT-1:0] free_sel;
  logic [BULLET_COUNT-1:0] spawn_oh;
  logic [BULLET_COUNT-1:0] hit;
  logic [10:0]             y_next [BULLET_COUNT];
  logic [10:0]             px, py;

  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};

  for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_slot
    logic [10:0] bx, by;
    logic        ovl_x, ovl_y;
    assign bx = {1'b0, ebullet_x[10*g +: 10]};
    assign by = {1'b0, ebullet_y[10*g +: 10]};
    assign ovl_x = (bx < px + 11'd32) && (bx + 11'd8 > px);
    assign ovl_y = (by < py + 11'd32) && (by + 11'd8 > py);
    assign hit[g] = ebullet_active[g] && ovl_x && ovl_y;
    assign y_next[g] = by + 11'(BULLET_SPEED);
  end

  // Lowest-index free slot, judged on the slot state at cycle start.
  always_comb begin
    free_any = 1'b0;
    free_sel = '0;
    for (int i = 0; i < BULLET_COUNT; i++) begin
      if (!ebullet_active[i] && !free_any) begin
        free_sel[i] = 1'b1;
        free_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (frame_tick) begin
      unique case (state)
        S_WAIT: begin
          if (!enemy_alive) begin
            cnt_n = '0;
          end else if (cnt == CW'(FIRE_PERIOD - 1)) begin
            state_n = S_ARMED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_ARMED: begin
          if (!enemy_alive || free_any) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    fire     = (state == S_ARMED) && frame_tick
               && enemy_alive && free_any;
    spawn_oh = fire ? free_sel : '0;
  end

  // Per slot: collision clear wins over retire, retire over move.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      ebullet_x      <= '0;
      ebullet_y      <= '0;
      ebullet_active <= '0;
      hit_mask       <= '0;
      player_hit     <= 1'b0;
      hit_count      <= '0;
    end else begin
      for (int i = 0; i < BULLET_COUNT; i++) begin
        if (hit[i]) begin
          ebullet_active[i] <= 1'b0;
        end else if (ebullet_active[i] && frame_tick) begin
          if (y_next[i] >= 11'(SCREEN_H))
            ebullet_active[i] <= 1'b0;
          else
            ebullet_y[10*i +: 10] <= y_next[i][9:0];
        end else if (spawn_oh[i]) begin
          ebullet_x[10*i +: 10] <= enemy_x + 10'd12;
          ebullet_y[10*i +: 10] <= enemy_y + 10'd32;
          ebullet_active[i]     <= 1'b1;
        end
      end
      hit_mask   <= hit;
      player_hit <= |hit;
      if (|hit && hit_count != 8'hFF)
        hit_count <= hit_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_enemy_bullet_controller.sv
// Random and directed stimulus for enemy_bullet_controller, checked
// every cycle against a slot-list reference model.
module tb_enemy_bullet_controller;

  localparam int N   = 4;
  localparam int SPD = 3;
  localparam int FP  = 45;
  localparam int SH  = 480;

  logic             clk25 = 1'b0;
  logic             rst_n;
  logic             frame_tick;
  logic             enemy_alive;
  logic [9:0]       enemy_x, enemy_y;
  logic [9:0]       player_x, player_y;
  logic [10*N-1:0]  ebullet_x, ebullet_y;
  logic [N-1:0]     ebullet_active;
  logic [N-1:0]     hit_mask;
  logic             player_hit;
  logic [7:0]       hit_count;

  always #20 clk25 = ~clk25;

  enemy_bullet_controller #(
    .BULLET_COUNT(N),
    .BULLET_SPEED(SPD),
    .FIRE_PERIOD(FP),
    .SCREEN_H(SH)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .enemy_alive(enemy_alive),
    .enemy_x(enemy_x),
    .enemy_y(enemy_y),
    .player_x(player_x),
    .player_y(player_y),
    .ebullet_x(ebullet_x),
    .ebullet_y(ebullet_y),
    .ebullet_active(ebullet_active),
    .hit_mask(hit_mask),
    .player_hit(player_hit),
    .hit_count(hit_count)
  );

  int total = 0;
  int bad   = 0;

  int mx [N];
  int my [N];
  bit ma [N];
  int m_ticks;
  bit m_armed;
  int m_hc;
  bit [N-1:0] m_hm;
  bit m_ph;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      my[i] = 0;
      ma[i] = 0;
    end
    m_ticks = 0;
    m_armed = 0;
    m_hc    = 0;
    m_hm    = '0;
    m_ph    = 0;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void m_step();
    bit h [N];
    int fs, px, py, ex, ey;
    bit fire, any;
    px = int'(player_x);
    py = int'(player_y);
    ex = int'(enemy_x);
    ey = int'(enemy_y);
    fs = -1;
    any = 0;
    for (int i = 0; i < N; i++) begin
      if (!ma[i] && fs < 0) fs = i;
      h[i] = ma[i] && mx[i] < px + 32 && mx[i] + 8 > px
             && my[i] < py + 32 && my[i] + 8 > py;
      any |= h[i];
    end
    fire = m_armed && frame_tick && enemy_alive && fs >= 0;
    for (int i = 0; i < N; i++) begin
      m_hm[i] = h[i];
      if (h[i]) begin
        ma[i] = 0;
      end else if (ma[i] && frame_tick) begin
        if (my[i] + SPD >= SH) ma[i] = 0;
        else my[i] = my[i] + SPD;
      end else if (fire && i == fs) begin
        mx[i] = (ex + 12) % 1024;
        my[i] = (ey + 32) % 1024;
        ma[i] = 1;
      end
    end
    m_ph = any;
    if (any && m_hc < 255) m_hc++;
    if (frame_tick) begin
      if (!m_armed) begin
        if (!enemy_alive) begin
          m_ticks = 0;
        end else begin
          m_ticks++;
          if (m_ticks == FP) begin
            m_armed = 1;
            m_ticks = 0;
          end
        end
      end else if (!enemy_alive || fs >= 0) begin
        m_armed = 0;
        m_ticks = 0;
      end
    end
  endfunction

  task automatic compare(input string pfx);
    logic [10*N-1:0] ex, ey;
    logic [N-1:0] ea;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = mx[i][9:0];
      ey[10*i +: 10] = my[i][9:0];
      ea[i] = ma[i];
    end
    chk({pfx, "_x"}, 64'(ebullet_x), 64'(ex));
    chk({pfx, "_y"}, 64'(ebullet_y), 64'(ey));
    chk({pfx, "_act"}, 64'(ebullet_active), 64'(ea));
    chk({pfx, "_mask"}, 64'(hit_mask), 64'(m_hm));
    chk({pfx, "_phit"}, 64'(player_hit), 64'(m_ph));
    chk({pfx, "_cnt"}, 64'(hit_count), 64'(m_hc));
  endtask

  task automatic step(input bit tick, input string pfx);
    frame_tick = tick;
    if (!rst_n) m_reset();
    else m_step();
    @(posedge clk25);
    #1;
    compare(pfx);
  endtask

  task automatic pulse_reset();
    #4;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare("arst");
    step(1'b1, "inrst");
    step(1'b0, "inrst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_tick  = 1'b0;
    enemy_alive = 1'b0;
    enemy_x     = 10'd304;
    enemy_y     = 10'd100;
    player_x    = 10'd0;
    player_y    = 10'd0;
    m_reset();
    #3;
    compare("reset");
    step(1'b0, "reset");
    rst_n = 1'b1;

    // First shot lands on the 46th frame tick.
    enemy_alive = 1'b1;
    for (int k = 1; k <= 45; k++) step(1'b1, "t1");
    chk("t1_none_at45", 64'(ebullet_active), 64'd0);
    step(1'b1, "t1");
    chk("t1_act", 64'(ebullet_active), 64'b0001);
    chk("t1_x0", 64'(ebullet_x[9:0]), 64'd316);
    chk("t1_y0", 64'(ebullet_y[9:0]), 64'd132);

    // Player parked under the muzzle so every shot hits; drives count to saturation.
    player_x = 10'd304;
    player_y = 10'd132;
    for (int k = 0; k < 260 * (FP + 1); k++) step(1'b1, "sat");
    chk("sat_cnt", 64'(hit_count), 64'd255);

    pulse_reset();
    chk("post_rst_cnt", 64'(hit_count), 64'd0);

    for (int k = 0; k < 16000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        enemy_x     = 10'($urandom_range(0, 1023));
        enemy_y     = 10'($urandom_range(0, 470));
        enemy_alive = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 99) == 0) begin
        player_x = 10'($urandom_range(0, 640));
        player_y = ($urandom_range(0, 1) == 1)
                   ? 10'($urandom_range(380, 479))
                   : 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 2999) == 0) pulse_reset();
      step($urandom_range(0, 2) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
